wb_mem_slave: RTL and testbench
===============================

Name: wb_mem_slave

Overview:
- Wishbone classic (non-pipelined) responder: a word-addressed, byte-lane-writable data memory sitting on the slave side of the pipeline's Wishbone bridge.
- Accepts single read/write cycles from the bridge's wbs_* outputs.
- Inserts a configurable number of wait states.
- Terminates each cycle with exactly one ack or err pulse.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
- WAIT_STATES, 0, extra cycles between acceptance and response; range 0..15.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- wbs_cyc_i  in  1  bus cycle in progress
- wbs_stb_i  in  1  strobe, valid request
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_sel_i  in  4  byte-lane selects, bit n = dat[8n+7:8n]
- wbs_we_i  in  1  1 = write, 0 = read
- wbs_dat_o  out  32  read data, valid only while ack is high on a read
- wbs_ack_o  out  1  normal termination, one-cycle pulse
- wbs_err_o  out  1  error termination, one-cycle pulse

Interface (already decided): one clock, clk_i; reset rst_i is synchronous and active-high.

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE; wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0; wait counter 0; captured request registers 0. Memory array is not cleared. Reset overrides any in-flight cycle; a pending write is dropped.
- States (one-hot): IDLE=3'b001, WAIT=3'b010, RESP=3'b100.
- IDLE: at an edge with cyc_i & stb_i = 1, capture adr, dat, sel and we into registers and evaluate the error condition.
  - WAIT_STATES=0: go to RESP.
  - Otherwise: load the counter with WAIT_STATES and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - If cyc_i=0 or stb_i=0 at any edge: abort to IDLE; no write, no ack, no err.
  - When the counter reaches 1 and the request is still valid: go to RESP.
- RESP (exactly one cycle): ack_o or err_o =1; always go to IDLE at the next edge. Requests are never sampled in RESP, so a master that drops stb after seeing ack is never double-accepted.
- Latency: acceptance at edge E. Ack/err is high during the cycle following edge E+WAIT_STATES and low otherwise. Back-to-back accesses: minimum 2 + WAIT_STATES cycles per access.
- Error condition, evaluated at capture:
  - adr[1:0] != 0, or
  - adr outside [BASE_ADDR, BASE_ADDR + DEPTH_WORDS*4 - 1].
  - On error: err_o pulses instead of ack_o, no memory write, dat_o = 0.
- Write: on the edge entering RESP, for each n with sel[n]=1, mem[word][8n+7:8n] <= dat[8n+7:8n]. Unselected lanes are unchanged. sel=4'b0000 still acks with no change.
- Read: on the edge entering RESP, dat_o <= mem[word], a full word regardless of sel. dat_o returns to 0 on the edge leaving RESP.
- Word index: (adr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
- ack_o and err_o are never both 1. Neither is ever asserted while cyc_i was 0 at acceptance.
- Request inputs are not re-sampled after capture: changes to adr, dat, sel or we during WAIT are ignored. Only cyc/stb are monitored, for abort.

Decomposition:
- Shared package wb_pkg holds:
  - state localparams IDLE/WAIT/RESP (3-bit one-hot);
  - WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4;
  - the state typedef.
- One natural sub-module, wb_bytelane_ram: DEPTH_WORDS×32 array with 4 byte-write enables and a synchronous read port. It has no reset.
- FSM, counter, decode and error logic live in wb_mem_slave.

Test Plan:
- WAIT_STATES=0: write adr 0x10, dat 0xDEADBEEF, sel 4'hF; then read 0x10. Each ack is a single pulse exactly 1 cycle after acceptance, and the read returns 0xDEADBEEF with ack.
- Byte lanes: write 0x11223344 to 0x20, then write 0x000000AA to 0x20 with sel=4'b0001 → read returns 0x112233AA. A write with sel=4'b0000 acks and leaves 0x112233AA.
- WAIT_STATES=3: a read is acked on the 4th cycle after acceptance. Master holds stb high through the ack edge → exactly one ack, no second acceptance.
- Errors:
  - Misaligned read at 0x22 → err pulse 1+WAIT_STATES cycles after acceptance, ack=0, dat_o=0.
  - Write to BASE_ADDR + DEPTH_WORDS*4 → err, and word 0 is not overwritten.
- Abort: WAIT_STATES=3, write 0xCAFEF00D to 0x30, drop cyc and stb after 1 wait cycle → no ack/err, and a later read of 0x30 returns the old value.
- Reset mid-operation: assert rst_i during WAIT of a write → next cycle ack=err=0 and dat_o=0, write not performed, earlier memory contents preserved, and the next request is accepted normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone widths and the one-hot state encoding of the memory responder.
package wb_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  localparam logic [2:0] IDLE = 3'b001;
  localparam logic [2:0] WAIT = 3'b010;
  localparam logic [2:0] RESP = 3'b100;

  typedef enum logic [2:0] {
    StIdle = IDLE,
    StWait = WAIT,
    StResp = RESP
  } state_e;

endpackage

// File: rtl/wb_mem_slave_if.sv
// Wishbone classic request/response bundle between the bridge (master) and a responder.
interface wb_mem_slave_if;
  import wb_pkg::*;

  logic                cyc;
  logic                stb;
  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] dat_wr;
  logic [WB_SEL_W-1:0] sel;
  logic                we;
  logic [WB_DAT_W-1:0] dat_rd;
  logic                ack;
  logic                err;

  modport master (
    output cyc, stb, adr, dat_wr, sel, we,
    input  dat_rd, ack, err
  );

  modport slave (
    input  cyc, stb, adr, dat_wr, sel, we,
    output dat_rd, ack, err
  );

endinterface

// File: rtl/wb_bytelane_ram.sv
// Word-wide memory with per-byte write enables and a registered read port; no reset.
module wb_bytelane_ram
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic                clk_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [WB_SEL_W-1:0] be_i,
  input  logic [WB_DAT_W-1:0] wdata_i,
  output logic [WB_DAT_W-1:0] rdata_o
);

  logic [WB_DAT_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    for (int n = 0; n < WB_SEL_W; n++) begin
      if (be_i[n]) begin
        mem[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
      end
    end
    rdata_o <= mem[addr_i];
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic memory responder: single-cycle accept, optional wait states,
// one ack or err pulse per accepted cycle, abort on cyc/stb drop during wait.
module wb_mem_slave
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic           clk_i,
  input logic           rst_i,
  wb_mem_slave_if.slave wbs
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AW-1:0]       idx_q;
  logic [WB_DAT_W-1:0] dat_q;
  logic [WB_SEL_W-1:0] sel_q;
  logic                we_q, err_q;

  logic                req_valid, accept, enter_resp;
  logic [31:0]         in_off;
  logic                in_err;
  logic                in_idle;
  logic [AW-1:0]       cur_idx;
  logic [WB_DAT_W-1:0] cur_dat;
  logic [WB_SEL_W-1:0] cur_sel;
  logic                cur_we, cur_err, mem_wr;
  logic [WB_DAT_W-1:0] ram_rdata;

  assign req_valid = wbs.cyc & wbs.stb;
  // Below-base addresses wrap to a huge offset and fail the range test too.
  assign in_off = wbs.adr - BASE_ADDR;
  assign in_err = (wbs.adr[1:0] != 2'b00) | ({1'b0, in_off} >= SPAN);

  // With zero wait states the RAM acts on the accepting edge, before capture lands.
  assign in_idle = (state_q == StIdle);
  assign cur_idx = in_idle ? in_off[AW+1:2] : idx_q;
  assign cur_dat = in_idle ? wbs.dat_wr     : dat_q;
  assign cur_sel = in_idle ? wbs.sel        : sel_q;
  assign cur_we  = in_idle ? wbs.we         : we_q;
  assign cur_err = in_idle ? in_err         : err_q;
  assign mem_wr  = enter_resp & cur_we & ~cur_err;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (!req_valid) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q <= in_off[AW+1:2];
        dat_q <= wbs.dat_wr;
        sel_q <= wbs.sel;
        we_q  <= wbs.we;
        err_q <= in_err;
      end
    end
  end

  wb_bytelane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk_i  (clk_i),
    .addr_i (cur_idx),
    .be_i   (cur_sel & {WB_SEL_W{mem_wr}}),
    .wdata_i(cur_dat),
    .rdata_o(ram_rdata)
  );

  assign wbs.ack    = (state_q == StResp) & ~err_q;
  assign wbs.err    = (state_q == StResp) & err_q;
  assign wbs.dat_rd = ((state_q == StResp) & ~err_q & ~we_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Scoreboard bench: two responders (0 and 3 wait states); stimulus pushes expected
// responses, a negedge monitor pops and checks every ack/err it observes.
module tb_wb_mem_slave;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_mem_slave_if bus0 ();
  wb_mem_slave_if bus1 ();

  wb_mem_slave #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0000_0000),
    .WAIT_STATES(0)
  ) dut0 (
    .clk_i(clk),
    .rst_i(rst),
    .wbs  (bus0)
  );

  wb_mem_slave #(
    .DEPTH_WORDS(64),
    .BASE_ADDR  (32'h0000_1000),
    .WAIT_STATES(3)
  ) dut1 (
    .clk_i(clk),
    .rst_i(rst),
    .wbs  (bus1)
  );

  typedef struct {
    bit          is_err;
    bit          chk_dat;
    logic [31:0] dat;
    int unsigned cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc_n = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc_n, got, want);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic mon(input int d, input logic ack, input logic err, input logic [31:0] dat);
    exp_t e;
    check($sformatf("dut%0d ack&err", d), 32'(ack & err), 32'd0);
    if (ack === 1'b1 || err === 1'b1) begin
      if (qsize(d) == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dut%0d spurious at cycle %0d: got ack=%b err=%b, want none", d, cyc_n,
                 ack, err);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("dut%0d err", d), 32'(err), 32'(e.is_err));
        check($sformatf("dut%0d ack", d), 32'(ack), 32'(!e.is_err));
        check($sformatf("dut%0d latency", d), cyc_n, e.cyc);
        if (e.chk_dat) check($sformatf("dut%0d rdata", d), dat, e.dat);
      end
    end else begin
      check($sformatf("dut%0d idle dat", d), dat, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.ack, bus0.err, bus0.dat_rd);
    mon(1, bus1.ack, bus1.err, bus1.dat_rd);
  end

  task automatic drive(input int d, input bit c, input bit s, input bit w,
                       input logic [31:0] a, input logic [31:0] dt, input logic [3:0] sl);
    if (d == 0) begin
      bus0.cyc = c; bus0.stb = s; bus0.we = w; bus0.adr = a; bus0.dat_wr = dt; bus0.sel = sl;
    end else begin
      bus1.cyc = c; bus1.stb = s; bus1.we = w; bus1.adr = a; bus1.dat_wr = dt; bus1.sel = sl;
    end
  endtask

  // Entered and left at #1 after a rising edge; stb is held through the ack edge.
  task automatic access(input int d, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input bit exp_err, input logic [31:0] exp_dat);
    exp_t e;
    bit   done = 1'b0;
    int   w    = (d == 0) ? 0 : 3;
    drive(d, 1'b1, 1'b1, we, adr, dat, sel);
    e.is_err  = exp_err;
    e.chk_dat = exp_err || !we;
    e.dat     = exp_err ? 32'd0 : exp_dat;
    e.cyc     = cyc_n + 1 + w;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    for (int i = 0; i < 30 && !done; i++) begin
      @(posedge clk);
      done = (qsize(d) == 0);
    end
    #1;
    drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL dut%0d timeout adr %h: got no response, want one", d, adr);
      if (d == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ack0", 32'(bus0.ack), 32'd0);
    check("reset err0", 32'(bus0.err), 32'd0);
    check("reset dat0", bus0.dat_rd, 32'd0);
    check("reset ack1", 32'(bus1.ack), 32'd0);
    check("reset err1", 32'(bus1.err), 32'd0);
    check("reset dat1", bus1.dat_rd, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero wait states, full word then byte lanes.
    access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'd0);
    access(0, 1'b0, 32'h10, 32'd0,         4'hF, 1'b0, 32'hDEAD_BEEF);
    access(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 32'd0);
    access(0, 1'b1, 32'h20, 32'h0000_00AA, 4'h1, 1'b0, 32'd0);
    access(0, 1'b0, 32'h20, 32'd0,         4'h0, 1'b0, 32'h1122_33AA);
    access(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'd0);
    access(0, 1'b0, 32'h20, 32'd0,         4'hF, 1'b0, 32'h1122_33AA);
    access(0, 1'b1, 32'h24, 32'h0000_0000, 4'hF, 1'b0, 32'd0);
    access(0, 1'b1, 32'h24, 32'hAABB_CCDD, 4'hA, 1'b0, 32'd0);
    access(0, 1'b0, 32'h24, 32'd0,         4'hF, 1'b0, 32'hAA00_CC00);
    // Errors: misaligned, one past the end (aliases word 0 if not caught).
    access(0, 1'b0, 32'h22,   32'd0,         4'hF, 1'b1, 32'd0);
    access(0, 1'b1, 32'h0,    32'h1234_5678, 4'hF, 1'b0, 32'd0);
    access(0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0);
    access(0, 1'b0, 32'h0,    32'd0,         4'hF, 1'b0, 32'h1234_5678);

    // Three wait states, base 0x1000, 64 words.
    access(1, 1'b1, 32'h1030, 32'h0BAD_C0DE, 4'hF, 1'b0, 32'd0);
    access(1, 1'b0, 32'h1030, 32'd0,         4'hF, 1'b0, 32'h0BAD_C0DE);
    access(1, 1'b0, 32'h1022, 32'd0,         4'hF, 1'b1, 32'd0);
    access(1, 1'b1, 32'h1000, 32'h55AA_55AA, 4'hF, 1'b0, 32'd0);
    access(1, 1'b1, 32'h1100, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0);
    access(1, 1'b0, 32'h1000, 32'd0,         4'hF, 1'b0, 32'h55AA_55AA);
    access(1, 1'b0, 32'h0FFC, 32'd0,         4'hF, 1'b1, 32'd0);

    // Abort after one wait cycle: no response, memory untouched.
    drive(1, 1'b1, 1'b1, 1'b1, 32'h1030, 32'hCAFE_F00D, 4'hF);
    repeat (2) @(posedge clk);
    #1 drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (8) @(posedge clk);
    #1;
    access(1, 1'b0, 32'h1030, 32'd0, 4'hF, 1'b0, 32'h0BAD_C0DE);

    // Reset during the wait of a write.
    drive(1, 1'b1, 1'b1, 1'b1, 32'h1030, 32'h9999_9999, 4'hF);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk);
    check("post-reset ack1", 32'(bus1.ack), 32'd0);
    check("post-reset err1", 32'(bus1.err), 32'd0);
    check("post-reset dat1", bus1.dat_rd, 32'd0);
    @(posedge clk);
    #1;
    access(1, 1'b0, 32'h1030, 32'd0, 4'hF, 1'b0, 32'h0BAD_C0DE);
    access(1, 1'b0, 32'h1000, 32'd0, 4'hF, 1'b0, 32'h55AA_55AA);

    repeat (10) @(posedge clk);
    check("q0 drained", 32'(q0.size()), 32'd0);
    check("q1 drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
